// File: rtl/fp_accum_seq.sv
// Sequential FP32 accumulator: sums a valid/ready stream of LEN operands through one
// combinational truncating adder and reports the total with a one-cycle done pulse.
module fp_accum_seq #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  sum
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   first_q, first_d;

  // fp_add_subtract: A=acc_q, B=in_data, R=add_r. Implicit leading 1, truncation only.
  logic [31:0] add_a, add_b, add_r, op_big, op_sml;
  logic [7:0]  e_big, e_diff;
  logic [23:0] m_big, m_sml, m_diff, m_norm;
  logic [24:0] m_sum;
  logic [4:0]  lz;

  always_comb begin
    add_a  = acc_q;
    add_b  = in_data;
    add_r  = 32'h0;
    lz     = 5'd0;
    if (add_a[30:0] >= add_b[30:0]) begin
      op_big = add_a;
      op_sml = add_b;
    end else begin
      op_big = add_b;
      op_sml = add_a;
    end
    e_big  = op_big[30:23];
    e_diff = op_big[30:23] - op_sml[30:23];
    m_big  = {1'b1, op_big[22:0]};
    m_sml  = (e_diff > 8'd23) ? 24'h0 : ({1'b1, op_sml[22:0]} >> e_diff);
    m_sum  = {1'b0, m_big} + {1'b0, m_sml};
    m_diff = m_big - m_sml;
    for (int i = 0; i < 24; i++) begin
      if (m_diff[i]) lz = 5'(23 - i);
    end
    m_norm = m_diff << lz;
    if (add_a[30:0] == 31'h0 && add_b[30:0] == 31'h0) begin
      add_r = 32'h0;
    end else if (op_big[31] == op_sml[31]) begin
      if (m_sum[24]) add_r = {op_big[31], e_big + 8'd1, m_sum[23:1]};
      else           add_r = {op_big[31], e_big, m_sum[22:0]};
    end else if (m_diff == 24'h0 || {3'b000, lz} >= e_big) begin
      add_r = 32'h0;
    end else begin
      add_r = {op_big[31], e_big - {3'b000, lz}, m_norm[22:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d = StAccum;
            cnt_d   = len;
            first_d = 1'b1;
          end else begin
            state_d = StDone;
            acc_d   = '0;
          end
        end
      end
      StAccum: begin
        if (in_valid) begin
          cnt_d   = cnt_q - 1'b1;
          first_d = 1'b0;
          acc_d   = first_q ? in_data : add_r;
          if (cnt_q == COUNT_WIDTH'(1)) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    // Load sum on entry to DONE so it is visible alongside the done pulse.
    if (state_d == StDone && state_q != StDone) sum_d = acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign in_ready = (state_q == StAccum);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed self-checking bench for fp_accum_seq with hand-computed FP32 sums.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] sum;

  int n_checks = 0;
  int n_errors = 0;
  int beats    = 0;
  int dones    = 0;

  fp_accum_seq #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid && in_ready) beats <= beats + 1;
    if (done) dones <= dones + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'hAA;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #12;
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_ready", {31'h0, in_ready}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_sum", sum, 32'h0);
    @(negedge clk); rst = 1'b0;
    tick();

    // 1+2+3 back to back
    cmd(8'd3);
    check_eq("t1_ready", {31'h0, in_ready}, 32'h1);
    check_eq("t1_busy", {31'h0, busy}, 32'h1);
    in_valid = 1'b1;
    in_data = 32'h3F800000; tick();
    in_data = 32'h40000000; tick();
    in_data = 32'h40400000; tick();
    in_valid = 1'b0;
    check_eq("t1_done", {31'h0, done}, 32'h1);
    check_eq("t1_sum", sum, 32'h40C00000);
    tick();
    check_eq("t1_done_pulse", {31'h0, done}, 32'h0);
    check_eq("t1_idle", {31'h0, busy}, 32'h0);
    check_eq("t1_sum_hold", sum, 32'h40C00000);

    // len == 0
    cmd(8'd0);
    check_eq("t2_done", {31'h0, done}, 32'h1);
    check_eq("t2_sum", sum, 32'h0);
    check_eq("t2_ready", {31'h0, in_ready}, 32'h0);
    tick();
    check_eq("t2_done_pulse", {31'h0, done}, 32'h0);
    check_eq("t2_ready2", {31'h0, in_ready}, 32'h0);

    // 2 + (-2) with gaps carrying junk data
    cmd(8'd2);
    beat(32'h40000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_gap_done", {31'h0, done}, 32'h0);
      check_eq("t3_gap_ready", {31'h0, in_ready}, 32'h1);
    end
    beat(32'hC0000000);
    check_eq("t3_done", {31'h0, done}, 32'h1);
    check_eq("t3_sum", sum, 32'h0);
    tick();

    // 4 x 1.0, stray start during ACCUM
    beats = 0;
    cmd(8'd4);
    beat(32'h3F800000);
    start = 1'b1; len = 8'd9;
    beat(32'h3F800000);
    start = 1'b0;
    beat(32'h3F800000);
    beat(32'h3F800000);
    in_valid = 1'b1; in_data = 32'h3F800000;
    check_eq("t4_done", {31'h0, done}, 32'h1);
    check_eq("t4_sum", sum, 32'h40800000);
    check_eq("t4_ready_done", {31'h0, in_ready}, 32'h0);
    tick();
    in_valid = 1'b0;
    check_eq("t4_beats", beats, 32'd4);
    check_eq("t4_idle", {31'h0, busy}, 32'h0);

    // abort by reset mid-ACCUM
    cmd(8'd5);
    beat(32'h3F800000);
    beat(32'h3F800000);
    dones = 0;
    #2 rst = 1'b1;
    #1;
    check_eq("t5_busy", {31'h0, busy}, 32'h0);
    check_eq("t5_ready", {31'h0, in_ready}, 32'h0);
    check_eq("t5_sum", sum, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t5_no_done", dones, 32'd0);
    cmd(8'd1);
    beat(32'h3F800000);
    check_eq("t5_done", {31'h0, done}, 32'h1);
    check_eq("t5_sum2", sum, 32'h3F800000);
    tick();

    // single negative operand, then immediate restart
    cmd(8'd1);
    beat(32'hC0A00000);
    check_eq("t6_done", {31'h0, done}, 32'h1);
    check_eq("t6_sum", sum, 32'hC0A00000);
    tick();
    cmd(8'd2);
    check_eq("t6_restart", {31'h0, busy}, 32'h1);
    beat(32'h3F800000);
    beat(32'h3F800000);
    check_eq("t6_done2", {31'h0, done}, 32'h1);
    check_eq("t6_sum2", sum, 32'h40000000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
